// File: rtl/regfile_hilo.sv
// Architectural GPR file plus HI/LO pair, committed at the write-back edge.
// All reads are combinational and forward the value being retired this cycle.
module regfile_hilo #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              gpr_commit;

    // r0 is never written, so its storage stays at the reset value of zero.
    assign gpr_commit = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (gpr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (whilo) begin
            hi <= hi_i;
            lo <= lo_i;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && raddr1 != '0 && re1) begin
            if (we && raddr1 == waddr) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && raddr2 != '0 && re2) begin
            if (we && raddr2 == waddr) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = whilo ? hi_i : hi;
            lo_o = whilo ? lo_i : lo;
        end
    end

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed and random checks of regfile_hilo against a behavioural model,
// with expected outputs queued when stimulus is driven and popped on sampling.
module tb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    regfile_hilo #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // Reference state, committed on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_hi <= 32'h0;
            m_lo <= 32'h0;
        end else begin
            if (we && waddr != 5'd0) m_regs[waddr] <= wdata;
            if (whilo) begin
                m_hi <= hi_i;
                m_lo <= lo_i;
            end
        end
    end

    function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
        if (rst)                  return 32'h0;
        if (a == 5'd0)            return 32'h0;
        if (e && we && a == waddr) return wdata;
        if (e)                    return m_regs[a];
        return 32'h0;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'h1, 32'h0);
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".rdata1"}, rdata1, e.r1);
        cmp({e.tag, ".rdata2"}, rdata2, e.r2);
        cmp({e.tag, ".hi_o"},   hi_o,   e.hi);
        cmp({e.tag, ".lo_o"},   lo_o,   e.lo);
    endtask

    // One cycle: drive at the falling edge, check against the model before the rising edge.
    task automatic step(input string tag, input logic r,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic hw, input logic [31:0] hv, input logic [31:0] lv,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        whilo = hw; hi_i = hv; lo_i = lv;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
        e.tag = tag;
        e.r1  = model_read(re1, raddr1);
        e.r2  = model_read(re2, raddr2);
        e.hi  = rst ? 32'h0 : (whilo ? hi_i : m_hi);
        e.lo  = rst ? 32'h0 : (whilo ? lo_i : m_lo);
        sb.push_back(e);
        pop_and_check();
    endtask

    // Fixed expectations for the current cycle, taken from the intended behaviour.
    task automatic expect_now(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] hv, input logic [31:0] lv);
        exp_t e;
        e.tag = tag; e.r1 = r1; e.r2 = r2; e.hi = hv; e.lo = lv;
        sb.push_back(e);
        pop_and_check();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        step("rst_c0", 1, 1, 5'd5, 32'hDEADBEEF, 1, 32'h5, 32'h6, 1, 5'd5, 1, 5'd5);
        expect_now("rst_c0_const", 32'h0, 32'h0, 32'h0, 32'h0);
        step("rst_c1", 1, 1, 5'd5, 32'hDEADBEEF, 1, 32'h5, 32'h6, 1, 5'd5, 1, 5'd5);
        step("rst_rel", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd5, 1, 5'd5);
        expect_now("rst_rel_const", 32'h0, 32'h0, 32'h0, 32'h0);

        step("wr_r7", 0, 1, 5'd7, 32'h12345678, 0, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0);
        step("rd_r7", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd7, 1, 5'd7);
        expect_now("rd_r7_const", 32'h12345678, 32'h12345678, 32'h0, 32'h0);
        step("rd_r7_re2off", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd7, 0, 5'd7);
        expect_now("rd_r7_re2off_const", 32'h12345678, 32'h0, 32'h0, 32'h0);

        step("wr_r3", 0, 1, 5'd3, 32'h1, 0, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0);
        step("byp_r3", 0, 1, 5'd3, 32'hA5A5A5A5, 0, 32'h0, 32'h0, 1, 5'd3, 1, 5'd3);
        expect_now("byp_r3_const", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0);
        step("byp_r3_held", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd3, 0, 5'd0);
        expect_now("byp_r3_held_const", 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0);
        step("byp_re_off", 0, 1, 5'd7, 32'hCAFEF00D, 0, 32'h0, 32'h0, 0, 5'd7, 1, 5'd3);
        expect_now("byp_re_off_const", 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0);

        step("r0_wr", 0, 1, 5'd0, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 1, 5'd0, 1, 5'd0);
        expect_now("r0_wr_const", 32'h0, 32'h0, 32'h0, 32'h0);
        step("r0_next", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd0, 1, 5'd0);
        expect_now("r0_next_const", 32'h0, 32'h0, 32'h0, 32'h0);

        step("hilo_wr", 0, 0, 5'd0, 32'h0, 1, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0);
        expect_now("hilo_wr_const", 32'h0, 32'h0, 32'h11, 32'h22);
        step("hilo_hold", 0, 0, 5'd0, 32'h0, 0, 32'h99, 32'h88, 0, 5'd0, 0, 5'd0);
        expect_now("hilo_hold_const", 32'h0, 32'h0, 32'h11, 32'h22);

        step("both_wr", 0, 1, 5'd12, 32'h0BADF00D, 1, 32'h33, 32'h44, 1, 5'd12, 1, 5'd7);
        step("both_rd", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd12, 1, 5'd31);
        expect_now("both_rd_const", 32'h0BADF00D, 32'h0, 32'h33, 32'h44);

        step("wr_r9", 0, 1, 5'd9, 32'h55, 0, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0);
        step("mid_rst", 1, 1, 5'd9, 32'h77, 1, 32'h1, 32'h2, 1, 5'd9, 1, 5'd9);
        expect_now("mid_rst_const", 32'h0, 32'h0, 32'h0, 32'h0);
        step("mid_rst_rel", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 1, 5'd9, 1, 5'd7);
        expect_now("mid_rst_rel_const", 32'h0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                 ($urandom_range(0, 2) == 0), $urandom(), $urandom(),
                 ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_hilo.md
Name: regfile_hilo

Overview:
Architectural state consumed directly downstream of the MEM/WB pipeline register. It holds the 32 general-purpose registers and the HI/LO pair, and commits write-back results at the clock edge. Decode reads operands through two read ports, and EX reads HI/LO. All reads are combinational and bypass a same-cycle write-back, so decode sees the value being retired this cycle.

Parameters:
DATA_W, 32, register data width (RegBus)
ADDR_W, 5, register address width (RegAddrBus)
NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
we  in  1  GPR write enable (from wb_wreg)
waddr  in  ADDR_W  GPR write address (from wb_wd)
wdata  in  DATA_W  GPR write data (from wb_wdata)
whilo  in  1  HI/LO write enable (from wb_whilo)
hi_i  in  DATA_W  HI write data (from wb_hi)
lo_i  in  DATA_W  LO write data (from wb_lo)
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data
hi_o  out  DATA_W  current HI (bypassed)
lo_o  out  DATA_W  current LO (bypassed)

Behaviour:
- Reset: clk rising edge with rst=1 clears all GPRs and HI, LO to 0. Any we/whilo in the same cycle is dropped.
- Combinational outputs while rst=1: rdata1, rdata2, hi_o, lo_o all 0.
- GPR write: at posedge, if rst=0, we=1 and waddr!=0, then regs[waddr] <= wdata.
- r0: writes to waddr=0 are ignored, and r0 always reads 0, including under bypass.
- HI/LO write: at posedge, if rst=0 and whilo=1, HI <= hi_i and LO <= lo_i together. The pair is never written separately.
- Read port n, evaluated in priority order, zero latency:
  - rst=1 -> 0
  - raddr==0 -> 0
  - re=1, we=1, raddr==waddr -> wdata (write-through bypass)
  - re=1 -> regs[raddr]
  - re=0 -> 0
- HI/LO read: if rst=1 -> 0; else if whilo=1 -> hi_i/lo_i; else stored HI/LO.
- Both read ports may address the same register and both get the bypass; the ports are fully independent.
- GPR write and HI/LO write in the same cycle are independent; both commit.
- No internal state beyond storage; no stall or flush inputs (bubbles arrive as we=0, whilo=0).
- Storage is flop-based and must not infer a RAM with registered read; bypass is required for pipeline correctness.

Test Plan:
- Reset: rst=1 for 2 cycles with we=1, waddr=5, wdata=0xDEADBEEF -> after release, re1=1, raddr1=5 reads 0; hi_o=lo_o=0.
- Write/read: write r7=0x12345678 at edge N -> from cycle N+1, raddr1=7 and raddr2=7 both read 0x12345678. With re2=0, rdata2=0.
- Bypass: in one cycle we=1, waddr=3, wdata=0xA5A5A5A5, stored r3=0x1, re1=1, raddr1=3 -> rdata1=0xA5A5A5A5 combinationally that cycle. r3 holds 0xA5A5A5A5 afterwards.
- r0: we=1, waddr=0, wdata=0xFFFFFFFF, with raddr1=0 the same cycle and the next -> rdata1=0 both cycles.
- HI/LO: whilo=1, hi_i=0x11, lo_i=0x22 -> hi_o/lo_o=0x11/0x22 the same cycle and after. The next cycle, whilo=0 with hi_i=0x99 -> hi_o stays 0x11.
- Reset mid-operation: r9=0x55 stored; assert rst with we=1, waddr=9, wdata=0x77 -> r9 reads 0 after release, not 0x77 or 0x55.
